// File: rtl/comparador_serial_izq_der.sv
// -----------------------------------------------------------------------------
// comparador_serial_izq_der
// Sequential MSB-first magnitude comparator. One operand pair is accepted
// through a valid/ready handshake. The pair is then scanned one bit per clock,
// starting at bit WIDTH-1. The result uses the same Z convention as the
// combinational Comparador (Z=1 when A<=B). It is held with valid/ready flow
// control toward the consumer.
//
// Parameters
//   WIDTH      operand width in bits (>=2)
//   EARLY_EXIT 1 = stop at the first differing bit, 0 = always scan WIDTH bits
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous active-high reset
//   in_valid   operand pair A/B present
//   in_ready   block can accept an operand pair (IDLE)
//   A, B       operands
//   out_valid  result valid (DONE)
//   out_ready  consumer accepts result
//   Z          1 when A<=B
//   GT/EQ/LT   A>B / A==B / A<B, exactly one set with a valid result
//   ciclos     number of bit positions examined (1..WIDTH)
// -----------------------------------------------------------------------------
module comparador_serial_izq_der #(
   parameter int WIDTH      = 8,
   parameter bit EARLY_EXIT = 1'b1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [WIDTH-1:0]             A,
   input  logic [WIDTH-1:0]             B,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic                         Z,
   output logic                         GT,
   output logic                         EQ,
   output logic                         LT,
   output logic [$clog2(WIDTH+1)-1:0]   ciclos
);

   localparam int IW = $clog2(WIDTH);
   localparam int CW = $clog2(WIDTH+1);

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t           state_reg;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [IW-1:0]    idx_reg;
   logic [CW-1:0]    count_reg;
   logic             diff_reg;     // a difference has already been recorded
   logic             gt_int_reg;   // recorded A>B, not yet published
   logic             lt_int_reg;   // recorded A<B, not yet published

   logic             bit_a;
   logic             bit_b;
   logic             first_diff;
   logic             rec_gt;
   logic             rec_lt;
   logic             finish;
   logic [CW-1:0]    count_next;

   // Per-bit decision for the current SCAN cycle. Only the first difference
   // is recorded; later bits never override it.
   always_comb begin
      bit_a      = a_reg[idx_reg];
      bit_b      = b_reg[idx_reg];
      first_diff = (bit_a ^ bit_b) & ~diff_reg;
      rec_gt     = gt_int_reg | (first_diff & bit_a);
      rec_lt     = lt_int_reg | (first_diff & bit_b);
      // idx==0 always ends the scan, so the index never wraps
      finish     = (EARLY_EXIT && first_diff) || (idx_reg == '0);
      count_next = count_reg + CW'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg  <= IDLE;
         in_ready   <= 1'b1;
         out_valid  <= 1'b0;
         Z          <= 1'b0;
         GT         <= 1'b0;
         EQ         <= 1'b0;
         LT         <= 1'b0;
         ciclos     <= '0;
         a_reg      <= '0;
         b_reg      <= '0;
         idx_reg    <= '0;
         count_reg  <= '0;
         diff_reg   <= 1'b0;
         gt_int_reg <= 1'b0;
         lt_int_reg <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (in_valid) begin
                  a_reg      <= A;
                  b_reg      <= B;
                  idx_reg    <= IW'(WIDTH-1);
                  count_reg  <= '0;
                  diff_reg   <= 1'b0;
                  gt_int_reg <= 1'b0;
                  lt_int_reg <= 1'b0;
                  in_ready   <= 1'b0;
                  state_reg  <= SCAN;
               end
            end
            SCAN: begin
               count_reg <= count_next;
               if (finish) begin
                  // Publish the result only now, so the previous one
                  // stays visible through IDLE and SCAN.
                  GT        <= rec_gt;
                  LT        <= rec_lt;
                  EQ        <= ~(rec_gt | rec_lt);
                  Z         <= ~rec_gt;
                  ciclos    <= count_next;
                  out_valid <= 1'b1;
                  state_reg <= DONE;
               end else begin
                  idx_reg    <= idx_reg - IW'(1);
                  diff_reg   <= diff_reg | first_diff;
                  gt_int_reg <= rec_gt;
                  lt_int_reg <= rec_lt;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state_reg <= IDLE;
               end
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_comparador_serial_izq_der.sv
// -----------------------------------------------------------------------------
// tb_comparador_serial_izq_der
// Two instances are used: inst 1 has EARLY_EXIT=1 and inst 0 has EARLY_EXIT=0.
// A transaction-level reference is kept in the bench. It computes the
// comparison arithmetically and counts down the expected number of scan
// cycles. The reference is checked against both instances on every falling
// edge. Directed transactions also carry hand-computed literal results.
// -----------------------------------------------------------------------------
module tb_comparador_serial_izq_der;

   localparam int W  = 8;
   localparam int CW = $clog2(W+1);

   typedef struct packed {
      logic          z;
      logic          gt;
      logic          eq;
      logic          lt;
      logic [CW-1:0] cyc;
   } res_t;

   logic                 clk = 1'b0;
   logic                 reset = 1'b1;
   logic [1:0]           in_valid_s = '0;
   logic [1:0]           in_ready_s;
   logic [1:0][W-1:0]    a_s = '0;
   logic [1:0][W-1:0]    b_s = '0;
   logic [1:0]           out_valid_s;
   logic [1:0]           out_ready_s = 2'b11;
   logic [1:0]           z_s, gt_s, eq_s, lt_s;
   logic [1:0][CW-1:0]   cic_s;

   int n_cmp = 0;
   int n_err = 0;
   int n_acc [2] = '{0, 0};
   int n_res [2] = '{0, 0};
   bit run_cmp = 1'b0;

   always #5 clk = ~clk;

   comparador_serial_izq_der #(.WIDTH(W), .EARLY_EXIT(1'b0)) dut0 (
      .clk(clk), .reset(reset),
      .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]),
      .A(a_s[0]), .B(b_s[0]),
      .out_valid(out_valid_s[0]), .out_ready(out_ready_s[0]),
      .Z(z_s[0]), .GT(gt_s[0]), .EQ(eq_s[0]), .LT(lt_s[0]),
      .ciclos(cic_s[0])
   );

   comparador_serial_izq_der #(.WIDTH(W), .EARLY_EXIT(1'b1)) dut1 (
      .clk(clk), .reset(reset),
      .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]),
      .A(a_s[1]), .B(b_s[1]),
      .out_valid(out_valid_s[1]), .out_ready(out_ready_s[1]),
      .Z(z_s[1]), .GT(gt_s[1]), .EQ(eq_s[1]), .LT(lt_s[1]),
      .ciclos(cic_s[1])
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: plain arithmetic comparison; the scan length is the distance
   // from the MSB to the highest differing bit, or W without early exit.
   function automatic res_t ref_cmp(input logic [W-1:0] a, input logic [W-1:0] b, input bit ee);
      res_t r;
      logic [W-1:0] x;
      int p;
      r.gt  = (a > b);
      r.lt  = (a < b);
      r.eq  = (a == b);
      r.z   = (a <= b);
      r.cyc = CW'(W);
      if (ee && a != b) begin
         x = a ^ b;
         p = 0;
         for (int i = 0; i < W; i++) if (x[i]) p = i;
         r.cyc = CW'(W - p);
      end
      return r;
   endfunction

   // Transaction-level timing reference: 0 idle, 1 scanning, 2 result held.
   int   m_phase [2];
   int   m_rem   [2];
   res_t m_pend  [2];
   res_t m_out   [2];

   always @(posedge clk or posedge reset) begin
      for (int k = 0; k < 2; k++) begin
         if (reset) begin
            m_phase[k] <= 0;
            m_rem[k]   <= 0;
            m_pend[k]  <= '0;
            m_out[k]   <= '0;
         end else begin
            case (m_phase[k])
               0: if (in_valid_s[k]) begin
                     m_pend[k]  <= ref_cmp(a_s[k], b_s[k], (k == 1));
                     m_rem[k]   <= int'(ref_cmp(a_s[k], b_s[k], (k == 1)).cyc);
                     m_phase[k] <= 1;
                  end
               1: if (m_rem[k] == 1) begin
                     m_out[k]   <= m_pend[k];
                     m_phase[k] <= 2;
                  end else begin
                     m_rem[k] <= m_rem[k] - 1;
                  end
               default: if (out_ready_s[k]) m_phase[k] <= 0;
            endcase
         end
      end
   end

   // Every-cycle comparison of both instances against the reference.
   always @(negedge clk) begin
      if (run_cmp) begin
         for (int k = 0; k < 2; k++) begin
            chk($sformatf("u%0d in_ready", k),  32'(in_ready_s[k]),  32'(m_phase[k] == 0));
            chk($sformatf("u%0d out_valid", k), 32'(out_valid_s[k]), 32'(m_phase[k] == 2));
            chk($sformatf("u%0d Z", k),         32'(z_s[k]),         32'(m_out[k].z));
            chk($sformatf("u%0d GT", k),        32'(gt_s[k]),        32'(m_out[k].gt));
            chk($sformatf("u%0d EQ", k),        32'(eq_s[k]),        32'(m_out[k].eq));
            chk($sformatf("u%0d LT", k),        32'(lt_s[k]),        32'(m_out[k].lt));
            chk($sformatf("u%0d ciclos", k),    32'(cic_s[k]),       32'(m_out[k].cyc));
            if (out_valid_s[k] && out_ready_s[k]) n_res[k]++;
         end
      end
   end

   // One transaction on instance k, consumer always ready. exp is the
   // expected result; pin=1 means exp was hand-computed and also pins ref_cmp.
   task automatic run_pair(input int k, input logic [W-1:0] a, input logic [W-1:0] b,
                           input res_t exp, input bit pin);
      int  lat;
      bit  got;
      @(posedge clk); #2;
      a_s[k] = a;
      b_s[k] = b;
      in_valid_s[k] = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (in_ready_s[k]) begin got = 1'b1; break; end
      end
      if (!got) chk($sformatf("u%0d accept timeout", k), 32'd0, 32'd1);
      @(posedge clk); #2;
      in_valid_s[k] = 1'b0;
      n_acc[k]++;
      lat = 0;
      got = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (out_valid_s[k]) begin got = 1'b1; break; end
         lat++;
      end
      if (!got) chk($sformatf("u%0d result timeout", k), 32'd0, 32'd1);
      if (pin) chk($sformatf("u%0d model A=%0h B=%0h", k, a, b),
                   32'(ref_cmp(a, b, (k == 1))), 32'(exp));
      chk($sformatf("u%0d latency", k), 32'(lat), 32'(exp.cyc));
      chk($sformatf("u%0d result", k), 32'({z_s[k], gt_s[k], eq_s[k], lt_s[k], cic_s[k]}), 32'(exp));
      $display("txn u%0d A=%02h B=%02h -> Z=%0b GT=%0b EQ=%0b LT=%0b ciclos=%0d lat=%0d",
               k, a, b, z_s[k], gt_s[k], eq_s[k], lt_s[k], cic_s[k], lat);
   endtask

   function automatic res_t mk(input logic gt, input logic eq, input logic lt, input int cyc);
      res_t r;
      r.z = ~gt; r.gt = gt; r.eq = eq; r.lt = lt; r.cyc = CW'(cyc);
      return r;
   endfunction

   initial begin
      logic [W-1:0] ra, rb;
      bit got;

      // Reset state
      @(posedge clk); #2;
      run_cmp = 1'b1;
      chk("reset in_ready", 32'(in_ready_s), 32'h3);
      chk("reset out_valid", 32'(out_valid_s), 32'h0);
      chk("reset flags", 32'({z_s, gt_s, eq_s, lt_s}), 32'h0);
      chk("reset ciclos", 32'(cic_s[1]), 32'h0);
      @(posedge clk); #2;
      reset = 1'b0;

      // Directed vectors
      run_pair(1, 8'h00, 8'h00, mk(0, 1, 0, 8), 1'b1);
      run_pair(1, 8'h6E, 8'h01, mk(1, 0, 0, 2), 1'b1);
      run_pair(0, 8'h6E, 8'h01, mk(1, 0, 0, 8), 1'b1);
      run_pair(1, 8'hE7, 8'h81, mk(1, 0, 0, 2), 1'b1);
      run_pair(1, 8'h00, 8'h01, mk(0, 0, 1, 8), 1'b1);
      run_pair(0, 8'h0A, 8'h09, mk(1, 0, 0, 8), 1'b1);

      // Backpressure: result must hold, new pair ignored
      @(posedge clk); #2;
      out_ready_s[1] = 1'b0;
      a_s[1] = 8'h0A; b_s[1] = 8'h09; in_valid_s[1] = 1'b1;
      @(posedge clk); #2;
      in_valid_s[1] = 1'b0;
      n_acc[1]++;
      got = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (out_valid_s[1]) begin got = 1'b1; break; end
      end
      if (!got) chk("bp result timeout", 32'd0, 32'd1);
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #2;
         if (c == 2) begin
            a_s[1] = 8'hFF; b_s[1] = 8'h00; in_valid_s[1] = 1'b1;
         end else begin
            in_valid_s[1] = 1'b0;
         end
         chk("bp hold", 32'({out_valid_s[1], in_ready_s[1], z_s[1], gt_s[1], cic_s[1]}),
             32'({1'b1, 1'b0, 1'b0, 1'b1, CW'(7)}));
      end
      in_valid_s[1] = 1'b0;
      out_ready_s[1] = 1'b1;
      @(posedge clk); #1;
      chk("bp release in_ready", 32'(in_ready_s[1]), 32'd1);
      chk("bp release out_valid", 32'(out_valid_s[1]), 32'd0);
      $display("txn u1 A=0a B=09 backpressure hold 5 cycles, ignored pair FF/00");

      // Reset in the 3rd SCAN cycle
      @(posedge clk); #2;
      a_s[1] = 8'h00; b_s[1] = 8'h00; in_valid_s[1] = 1'b1;
      @(posedge clk); #2;
      in_valid_s[1] = 1'b0;
      @(posedge clk);
      @(posedge clk); #2;
      reset = 1'b1;
      #1;
      chk("abort in_ready", 32'(in_ready_s[1]), 32'd1);
      chk("abort out_valid", 32'(out_valid_s[1]), 32'd0);
      chk("abort flags", 32'({z_s[1], gt_s[1], eq_s[1], lt_s[1], cic_s[1]}), 32'd0);
      $display("txn u1 A=00 B=00 aborted by reset in SCAN");
      @(posedge clk); #2;
      reset = 1'b0;
      run_pair(1, 8'h80, 8'h00, mk(1, 0, 0, 1), 1'b1);

      // Back-to-back random pairs against the reference
      for (int n = 0; n < 6; n++) begin
         ra = W'($urandom);
         rb = (n == 2) ? ra : W'($urandom);
         run_pair(1, ra, rb, ref_cmp(ra, rb, 1'b1), 1'b0);
      end
      for (int n = 0; n < 3; n++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         run_pair(0, ra, rb, ref_cmp(ra, rb, 1'b0), 1'b0);
      end

      @(posedge clk); #2;
      @(negedge clk);
      chk("u0 result count", 32'(n_res[0]), 32'(n_acc[0]));
      chk("u1 result count", 32'(n_res[1]), 32'(n_acc[1]));
      run_cmp = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
